// File: rtl/jpeg_stream_buffer.sv
// Captures one compressed JPEG byte stream into external RAM, then replays it in order through a 2-entry read FIFO.
// Optional macro JPEG_EOI_DETECT_EN also ends a load on the stored 0xFF,0xD9 EOI marker.
module jpeg_stream_buffer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     ram_ce,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0]    ram_data,
  output logic [ADDRESS_WIDTH:0]   length,
  output logic                     overflow,
  output logic                     done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDRESS_WIDTH:0]   LEN_ONE = 1;

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH:0]   r_length;
  logic                     r_overflow;
  logic [ADDRESS_WIDTH:0]   r_rd_addr;
  logic [ADDRESS_WIDTH:0]   r_out_cnt;
  logic                     r_inflight;
  logic [DATA_WIDTH-1:0]    r_fifo [2];
  logic                     r_fwr;
  logic                     r_frd;
  logic [1:0]               r_count;
  logic                     r_done;

  logic       w_go;
  logic       w_xfer;
  logic       w_full;
  logic       w_eoi;
  logic       w_term;
  logic       w_load_end;
  logic       w_pop;
  logic [2:0] w_occ;
  logic       w_issue;
  logic       w_last_acc;
  logic       w_empty;

`ifdef JPEG_EOI_DETECT_EN
  logic r_prev_ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_prev_ff <= 1'b0;
    else if (w_go)
      r_prev_ff <= 1'b0;
    else if (w_xfer)
      r_prev_ff <= (in_data == DATA_WIDTH'(8'hFF));
  end

  assign w_eoi = r_prev_ff && (in_data == DATA_WIDTH'(8'hD9));
`else
  assign w_eoi = 1'b0;
`endif

  assign w_go       = (r_state == S_IDLE) && start;
  assign w_xfer     = (r_state == S_LOAD) && in_valid;
  assign w_full     = &r_wr_ptr;
  assign w_term     = in_last || w_eoi;
  assign w_load_end = w_xfer && (w_term || w_full);
  assign w_pop      = out_valid && out_ready;
  // Counting the same-cycle pop lets the read pipeline sustain one byte per cycle.
  assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue    = (r_state == S_DRAIN) && (r_rd_addr < r_length) && (w_occ < 3'd2);
  assign w_last_acc = (r_state == S_DRAIN) && w_pop && ((r_out_cnt + LEN_ONE) == r_length);
  assign w_empty    = (r_state == S_DRAIN) && (r_length == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  if (w_load_end) w_next = S_DRAIN;
      S_DRAIN: if (w_last_acc || w_empty) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    ram_ce      = 1'b0;
    ram_we      = 1'b0;
    ram_address = '0;
    case (r_state)
      S_LOAD: begin
        in_ready    = 1'b1;
        ram_ce      = w_xfer;
        ram_we      = w_xfer;
        ram_address = r_wr_ptr;
      end
      S_DRAIN: begin
        ram_ce      = 1'b1;
        ram_address = r_rd_addr[ADDRESS_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  assign ram_data = (ram_ce && ram_we) ? in_data : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_length   <= '0;
      r_overflow <= 1'b0;
    end else if (w_go) begin
      r_wr_ptr   <= '0;
      r_length   <= '0;
      r_overflow <= 1'b0;
    end else if (w_xfer) begin
      r_wr_ptr <= r_wr_ptr + PTR_ONE;
      r_length <= r_length + LEN_ONE;
      if (w_full && !w_term)
        r_overflow <= 1'b1;
    end
  end

  // Read side: address issue, one-cycle RAM latency, then the 2-entry output FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_addr  <= '0;
      r_out_cnt  <= '0;
      r_inflight <= 1'b0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_fwr      <= 1'b0;
      r_frd      <= 1'b0;
      r_count    <= '0;
      r_done     <= 1'b0;
    end else if (w_go) begin
      r_rd_addr  <= '0;
      r_out_cnt  <= '0;
      r_inflight <= 1'b0;
      r_fwr      <= 1'b0;
      r_frd      <= 1'b0;
      r_count    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_last_acc || w_empty;
      if (w_issue)
        r_rd_addr <= r_rd_addr + LEN_ONE;
      if (r_inflight) begin
        r_fifo[r_fwr] <= ram_data;
        r_fwr         <= ~r_fwr;
      end
      if (w_pop) begin
        r_frd     <= ~r_frd;
        r_out_cnt <= r_out_cnt + LEN_ONE;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_fifo[r_frd];
  assign length    = r_length;
  assign overflow  = r_overflow;
  assign done      = r_done;

endmodule
